// File: rtl/alu8x8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu8x8_pkg                                                  |
// | Brief   : Opcodes and widths shared by the alu_8x8_p datapath.        |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package alu8x8_pkg;

  localparam int ALU_W = 8;
  localparam int RES_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

endpackage : alu8x8_pkg
`default_nettype wire

// File: rtl/alu8x8_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu8x8_mul                                                  |
// | Brief   : Combinational 8x8 shift-and-add multiplier, 16-bit product. |
// |           ALU8X8_P_SIGNED_MUL_EN selects a two's-complement product;  |
// |           otherwise the product is unsigned.                          |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module alu8x8_mul
  import alu8x8_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [RES_W-1:0] p
);

`ifdef ALU8X8_P_SIGNED_MUL_EN
  localparam bit c_signed = 1'b1;
`else
  localparam bit c_signed = 1'b0;
`endif

  logic [RES_W-1:0] w_a_ext;
  logic [RES_W-1:0] w_pp;
  logic [RES_W-1:0] w_acc;

  // In signed mode the multiplicand is sign-extended and the MSB row of b
  // carries weight -128, so it is subtracted instead of added.
  always_comb begin
    w_a_ext = c_signed ? {{(RES_W-ALU_W){a[ALU_W-1]}}, a}
                       : {{(RES_W-ALU_W){1'b0}}, a};
    w_acc   = '0;
    w_pp    = '0;
    for (int i = 0; i < ALU_W; i++) begin
      w_pp = b[i] ? (w_a_ext << i) : '0;
      if (c_signed && (i == ALU_W-1)) begin
        w_acc = w_acc - w_pp;
      end else begin
        w_acc = w_acc + w_pp;
      end
    end
    p = w_acc;
  end

endmodule : alu8x8_mul
`default_nettype wire

// File: rtl/alu_8x8_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_8x8_p                                                   |
// | Brief   : Registered 8-bit ALU with 16-bit result, 1-cycle latency:   |
// |           add/sub with carry-in, multiply, logic, shift, compare.     |
// |           ALU8X8_P_SIGNED_MUL_EN makes opcode 010 a signed multiply.  |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module alu_8x8_p
  import alu8x8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [RES_W-1:0] res
);

  logic [ALU_W:0]   w_sum;
  logic [ALU_W:0]   w_diff;
  logic [RES_W-1:0] w_prod;
  logic [RES_W-1:0] w_shl;
  logic [RES_W-1:0] w_next;
  logic [RES_W-1:0] r_res;

  alu8x8_mul u_mul (
    .a (a),
    .b (b),
    .p (w_prod)
  );

  // Arithmetic and shift units; bit 8 of the 9-bit diff is the borrow.
  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
    w_diff = {1'b0, a} - {1'b0, b} - {{ALU_W{1'b0}}, cin};
    w_shl  = {{(RES_W-ALU_W){1'b0}}, a} << b[3:0];
  end

  // Operation select into the result register D-input.
  always_comb begin
    w_next = '0;
    case (op)
      OP_ADD:  w_next = {{(RES_W-ALU_W-1){1'b0}}, w_sum};
      OP_SUB:  w_next = {{(RES_W-ALU_W-1){1'b0}}, w_diff};
      OP_MUL:  w_next = w_prod;
      OP_AND:  w_next = {{(RES_W-ALU_W){1'b0}}, a & b};
      OP_OR:   w_next = {{(RES_W-ALU_W){1'b0}}, a | b};
      OP_XOR:  w_next = {{(RES_W-ALU_W){1'b0}}, a ^ b};
      OP_SHL:  w_next = w_shl;
      OP_CMP:  w_next = {13'b0, (a > b), (a == b), (a < b)};
      default: w_next = '0;
    endcase
  end

  // Result register, loaded every edge; reset wins over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else begin
      r_res <= w_next;
    end
  end

  assign res = r_res;

endmodule : alu_8x8_p
`default_nettype wire

// File: tb/tb_alu_8x8_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_8x8_p                                                |
// | Brief   : Self-checking bench for alu_8x8_p against an arithmetic     |
// |           reference model (honours ALU8X8_P_SIGNED_MUL_EN).           |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_alu_8x8_p;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic [2:0]  op;
  logic [15:0] res;

  int n_checks;
  int n_fail;

  alu_8x8_p dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .op  (op),
    .res (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the opcode definitions.
  function automatic logic [15:0] model(input int o, input int x, input int y, input int c);
    int r;
    int sx;
    int sy;
    r = 0;
    case (o)
      0: r = x + y + c;
      1: r = (512 + x - y - c) % 512;
      2: begin
`ifdef ALU8X8_P_SIGNED_MUL_EN
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
`else
        sx = x;
        sy = y;
`endif
        r = (sx * sy) & 32'hFFFF;
      end
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = (x << (y % 16)) & 32'hFFFF;
      default: r = (x > y) ? 4 : ((x == y) ? 2 : 1);
    endcase
    return r[15:0];
  endfunction

  // Present one operation, clock it in, check after the edge.
  task automatic do_op(input string tag, input int o, input int x, input int y, input int c);
    op  = o[2:0];
    a   = x[7:0];
    b   = y[7:0];
    cin = c[0];
    @(posedge clk);
    #1;
    check(tag, res, model(o, x, y, c));
  endtask

  initial begin
    int o;
    int x;
    int y;
    int c;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a   = 8'h5A;
    b   = 8'hA5;
    cin = 1'b1;
    op  = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    check("reset", res, 16'h0000);
    rst = 1'b0;

    // Directed cases, including the literal expected values.
    do_op("add_ff_01_c1", 0, 8'hFF, 8'h01, 1);
    check("add_ff_01_c1_lit", res, 16'h0101);
    do_op("add_12_34", 0, 8'h12, 8'h34, 0);
    check("add_12_34_lit", res, 16'h0046);
    do_op("sub_05_07", 1, 8'h05, 8'h07, 0);
    check("sub_05_07_lit", res, 16'h01FE);
    do_op("sub_07_05_c1", 1, 8'h07, 8'h05, 1);
    check("sub_07_05_c1_lit", res, 16'h0001);
    do_op("sub_00_ff_c1", 1, 8'h00, 8'hFF, 1);
    do_op("mul_ff_ff", 2, 8'hFF, 8'hFF, 1);
`ifdef ALU8X8_P_SIGNED_MUL_EN
    check("mul_ff_ff_lit", res, 16'h0001);
`else
    check("mul_ff_ff_lit", res, 16'hFE01);
`endif
    do_op("mul_00_9c", 2, 8'h00, 8'h9C, 0);
    check("mul_00_9c_lit", res, 16'h0000);
    do_op("mul_80_7f", 2, 8'h80, 8'h7F, 0);
    do_op("and_c1", 3, 8'hF0, 8'h3C, 1);
    check("and_lit", res, 16'h0030);
    do_op("or_c0", 4, 8'hF0, 8'h3C, 0);
    check("or_lit", res, 16'h00FC);
    do_op("xor_c1", 5, 8'hF0, 8'h3C, 1);
    check("xor_lit", res, 16'h00CC);
    do_op("shl_81_09", 6, 8'h81, 8'h09, 0);
    check("shl_81_09_lit", res, 16'h0200);
    do_op("shl_81_f0", 6, 8'h81, 8'hF0, 1);
    check("shl_81_f0_lit", res, 16'h0081);
    do_op("shl_ff_0f", 6, 8'hFF, 8'h0F, 0);
    do_op("cmp_lt", 7, 8'h10, 8'h20, 1);
    check("cmp_lt_lit", res, 16'h0001);
    do_op("cmp_eq", 7, 8'h20, 8'h20, 0);
    check("cmp_eq_lit", res, 16'h0002);
    do_op("cmp_gt", 7, 8'hFF, 8'h00, 1);
    check("cmp_gt_lit", res, 16'h0004);

    // Back-to-back stream, reset for one edge mid-stream, then resume.
    for (int i = 0; i < 8; i++) begin
      do_op("stream_pre", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    end
    rst = 1'b1;
    op  = 3'b000;
    a   = 8'hFF;
    b   = 8'h01;
    cin = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_stream", res, 16'h0000);
    rst = 1'b0;
    do_op("resume_add", 0, 8'hFF, 8'h01, 0);
    check("resume_add_lit", res, 16'h0100);
    do_op("resume_mul", 2, 8'h0C, 8'h0D, 0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 400; i++) begin
      o = int'($urandom_range(0, 7));
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 1));
      if (i % 16 == 0) y = x;
      do_op("random", o, x, y, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_8x8_p
`default_nettype wire
